// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: debounced door/window/fire sensors, a fire-alarm
// hold timer and a hysteretic heat/cool thermostat, all driving a single
// state register whose code is shown on the display.
module smart_home_ctrl_p #(
  parameter int TW         = 7,
  parameter int NW         = 4,
  parameter int DEB        = 3,
  parameter int T_LO       = 50,
  parameter int T_HI       = 60,
  parameter int HYST       = 2,
  parameter int ALARM_HOLD = 8,
  localparam int IW        = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          SFD,
  input  logic          SRD,
  input  logic [NW-1:0] SW,
  input  logic          SFA,
  input  logic [TW-1:0] ST,
  output logic          fdoor,
  output logic          rdoor,
  output logic          winbuzz,
  output logic [IW-1:0] win_idx,
  output logic          alarmbuzz,
  output logic          heater,
  output logic          cooler,
  output logic [2:0]    display
);

  // State codes double as the display value.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_FDOOR = 3'b001;
  localparam logic [2:0] S_RDOOR = 3'b010;
  localparam logic [2:0] S_ALARM = 3'b011;
  localparam logic [2:0] S_WIN   = 3'b100;
  localparam logic [2:0] S_HEAT  = 3'b101;
  localparam logic [2:0] S_COOL  = 3'b110;

  // Thresholds are compared unsigned at the temperature width.
  localparam logic [TW-1:0] HEAT_ENTER = TW'(T_LO);
  localparam logic [TW-1:0] HEAT_EXIT  = TW'(T_LO + HYST);
  localparam logic [TW-1:0] COOL_ENTER = TW'(T_HI);
  localparam logic [TW-1:0] COOL_EXIT  = TW'(T_HI - HYST);
  localparam logic [3:0]    DEB_C      = 4'(DEB);
  localparam logic [7:0]    HOLD_LOAD  = 8'(ALARM_HOLD - 1);

  // Debounced inputs: 0 = front door, 1 = rear door, 2 = fire, 3.. = windows.
  localparam int NS = NW + 3;

  logic [NS-1:0] sense;
  logic [NS-1:0] qual;
  logic [3:0]    cnt_reg [NS];

  assign sense = {SW, SFA, SRD, SFD};

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_deb
      // Saturating run-length counter: any low sample clears it.
      always_ff @(posedge clk) begin
        if (Rst)
          cnt_reg[gi] <= 4'd0;
        else if (!sense[gi])
          cnt_reg[gi] <= 4'd0;
        else if (cnt_reg[gi] != 4'hF)
          cnt_reg[gi] <= cnt_reg[gi] + 4'd1;
      end
      assign qual[gi] = (cnt_reg[gi] >= DEB_C);
    end
  endgenerate

  logic          fd_q, rd_q, fa_q;
  logic [NW-1:0] win_q;

  assign fd_q  = qual[0];
  assign rd_q  = qual[1];
  assign fa_q  = qual[2];
  assign win_q = qual[NS-1:3];

  logic [2:0]    state_reg, state_next;
  logic [7:0]    hold_reg;
  logic [IW-1:0] win_idx_reg, win_idx_next;

  // State register, alarm hold counter and window index register.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg   <= S_IDLE;
      hold_reg    <= 8'd0;
      win_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      win_idx_reg <= win_idx_next;
      if (state_reg != S_ALARM && state_next == S_ALARM)
        hold_reg <= HOLD_LOAD;
      else if (state_reg == S_ALARM && hold_reg != 8'd0)
        hold_reg <= hold_reg - 8'd1;
    end
  end

  // Lowest-index qualified window; keeps the old value when none is open.
  always_comb begin
    win_idx_next = win_idx_reg;
    for (int i = NW - 1; i >= 0; i--) begin
      if (win_q[i])
        win_idx_next = IW'(i);
    end
  end

  // Next state: alarm hold first, then sensor priority, then thermostat.
  always_comb begin
    state_next = S_IDLE;
    if (state_reg == S_ALARM && hold_reg != 8'd0)
      state_next = S_ALARM;
    else if (state_reg == 3'b111)
      state_next = S_IDLE;
    else if (fa_q)
      state_next = S_ALARM;
    else if (fd_q)
      state_next = S_FDOOR;
    else if (rd_q)
      state_next = S_RDOOR;
    else if (|win_q)
      state_next = S_WIN;
    else if (state_reg == S_HEAT && ST < HEAT_EXIT)
      state_next = S_HEAT;
    else if (state_reg == S_COOL && ST > COOL_EXIT)
      state_next = S_COOL;
    else if (ST < HEAT_ENTER)
      state_next = S_HEAT;
    else if (ST > COOL_ENTER)
      state_next = S_COOL;
  end

  // Actuators decode straight from the state register, so they are one-hot.
  always_comb begin
    fdoor     = (state_reg == S_FDOOR);
    rdoor     = (state_reg == S_RDOOR);
    alarmbuzz = (state_reg == S_ALARM);
    winbuzz   = (state_reg == S_WIN);
    heater    = (state_reg == S_HEAT);
    cooler    = (state_reg == S_COOL);
    display   = (state_reg == 3'b111) ? S_IDLE : state_reg;
    win_idx   = win_idx_reg;
  end

endmodule

// File: doc/smart_home_ctrl_p.md
SMART_HOME_CTRL_P -- requirements
Module: smart_home_ctrl_p

Interface
REQ-001 Parameter TW, default 7: width of temperature input ST (unsigned).
REQ-002 Parameter NW, default 4: number of window sensors.
REQ-003 Parameter DEB, default 3: consecutive high samples needed to qualify a door, window or alarm sensor (range 1..15).
REQ-004 Parameter T_LO, default 50: heating entry threshold.
REQ-005 Parameter T_HI, default 60: cooling entry threshold.
REQ-006 Parameter HYST, default 2: hysteresis band. Legal only when T_LO+HYST <= T_HI-HYST.
REQ-007 Parameter ALARM_HOLD, default 8: minimum cycles the ALARM state is held (range 1..255).
REQ-008 Clock and reset requirement: one clock; reset is synchronous and active-high.
REQ-009 Ports:
- clk  in  1  clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- SFD  in  1  front-door sensor.
- SRD  in  1  rear-door sensor.
- SW  in  NW  window sensors, bit i = window i.
- SFA  in  1  fire-alarm sensor.
- ST  in  TW  temperature.
- fdoor  out  1  front-door actuator.
- rdoor  out  1  rear-door actuator.
- winbuzz  out  1  window buzzer.
- win_idx  out  clog2(NW) (min 1)  lowest-index qualified open window.
- alarmbuzz  out  1  fire buzzer.
- heater  out  1  heater on.
- cooler  out  1  cooler on.
- display  out  3  current state code.

Function
REQ-010 State encoding on display: IDLE=000, FDOOR=001, RDOOR=010, ALARM=011, WIN=100, HEAT=101, COOL=110; 111 is never produced, and an illegal state goes to IDLE on the next edge.
REQ-011 Actuator outputs decode from the state register only:
- fdoor=FDOOR, rdoor=RDOOR, alarmbuzz=ALARM, winbuzz=WIN, heater=HEAT, cooler=COOL.
- At most one of these is high in any cycle.
REQ-012 Debounce (SFD, SRD, SFA, each SW bit):
- Per-input saturating counter; increments on a high sample, clears on a low sample.
- The qualified flag is high when count >= DEB.
- A single low sample drops the flag at that edge.
REQ-013 Latency: an input sampled high on edges k..k+DEB-1 qualifies at edge k+DEB-1; the state changes at edge k+DEB.
REQ-014 ST is not debounced; a temperature crossing changes the state at the next edge.
REQ-015 Next-state priority, evaluated every cycle from qualified flags: ALARM > FDOOR > RDOOR > WIN > temperature > IDLE.
REQ-016 ALARM hold:
- On entry to ALARM, a hold counter loads ALARM_HOLD-1.
- ALARM is held while the counter is nonzero, regardless of other inputs.
- When the counter is zero and SFA is unqualified, the next state is chosen by REQ-015.
REQ-017 While SFA stays qualified, ALARM persists indefinitely and the hold counter stays at zero (no reload).
REQ-018 Temperature, when no sensor is qualified:
- Enter HEAT if ST < T_LO; remain in HEAT while ST < T_LO+HYST.
- Enter COOL if ST > T_HI; remain in COOL while ST > T_HI-HYST.
- Otherwise IDLE.
REQ-019 HEAT and COOL never transition directly into each other without ST crossing the opposite entry threshold; a direct HEAT->COOL is legal only if ST > T_HI.
REQ-020 When a sensor preempts HEAT/COOL and later clears, hysteresis state is lost; re-entry uses the entry thresholds.
REQ-021 win_idx:
- Registered; updated every edge to the lowest i with a qualified SW[i].
- Holds its last value when no window is qualified.
- Meaningful only when winbuzz=1.
REQ-022 Comparisons are unsigned at width TW; parameters are truncated to TW bits.

Reset
REQ-023 While Rst=1 at an edge:
- State goes to IDLE; all debounce counters, flags and the hold counter go to 0; win_idx goes to 0.
- All actuator outputs go to 0 and display goes to 000 from that edge.
REQ-024 Rst has priority over every input, including mid-ALARM and mid-debounce.
REQ-025 After Rst falls, sensors need a full DEB fresh samples to qualify.

Verification
REQ-026 Reset, then SFD=1 for 3 cycles (defaults) -> display=001 and fdoor=1 on the 4th edge; SFD=0 -> display=000 on the next edge.
REQ-027 SFD=1 for 2 cycles, then 0, then 1 for 3 cycles -> no change until the 3rd consecutive high; a glitch never reaches FDOOR.
REQ-028 SFA qualified for 1 cycle then dropped -> alarmbuzz=1 for exactly 8 cycles, then IDLE; SFD qualified during the hold -> FDOOR only after the hold expires.
REQ-029 SFD and SW[2] qualified simultaneously -> FDOOR; SFD released -> WIN with win_idx=2; then SW[0] also qualified -> win_idx=0.
REQ-030 Temperature ramp:
- ST=49 -> HEAT; ST=51 -> HEAT; ST=52 -> IDLE.
- ST=61 -> COOL; ST=59 -> COOL; ST=58 -> IDLE.
REQ-031 Rst asserted mid-ALARM hold with SW[1] qualified -> display=000 at that edge; after release, WIN follows exactly DEB+1 edges later.
